// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor (A - B - BIN), LSB first, start/done handshake
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic a_bit, b_bit, diff_bit, borrow_bit;

    // Single full-subtractor cell fed by the LSBs of the operand shift registers
    always_comb begin
        a_bit      = sa_q[0];
        b_bit      = sb_q[0];
        diff_bit   = a_bit ^ b_bit ^ br_q;
        borrow_bit = (~a_bit & b_bit) | (br_q & ~(a_bit ^ b_bit));
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    sa_d    = A;
                    sb_d    = B;
                    br_d    = BIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_d  = {diff_bit, sr_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                br_d  = borrow_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    d_d     = {diff_bit, sr_q[WIDTH-1:1]};
                    bout_d  = borrow_bit;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    // BUSY is the registered state itself, so outputs never see inputs combinationally
    assign BUSY = (state_q == RUN);
    assign DONE = done_q;
    assign D    = d_q;
    assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (WIDTH=8 directed/random, WIDTH=5 random)
module tb_serial_sub;

    logic       CLK;
    logic       RST_N;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, d8;
    logic       start5, bin5, busy5, done5, bout5;
    logic [4:0] a5, b5, d5;

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .RST_N(RST_N), .START(start8), .A(a8), .B(b8), .BIN(bin8),
        .BUSY(busy8), .DONE(done8), .D(d8), .BOUT(bout8)
    );

    serial_sub #(.WIDTH(5)) u_dut5 (
        .CLK(CLK), .RST_N(RST_N), .START(start5), .A(a5), .B(b5), .BIN(bin5),
        .BUSY(busy5), .DONE(done5), .D(d5), .BOUT(bout5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // counts edges (after the accept edge) until DONE is seen, bounded
    task automatic wait_done8(input int first, output int lat);
        lat = first;
        while (!done8 && lat < 30) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat);
        @(negedge CLK);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(posedge CLK);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait_done8(0, lat);
    endtask

    task automatic op5(input logic [4:0] a, input logic [4:0] b, input logic bin, output int lat);
        @(negedge CLK);
        start5 = 1'b1; a5 = a; b5 = b; bin5 = bin;
        @(posedge CLK);
        #1;
        start5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom); bin5 = 1'($urandom);
        lat = 0;
        while (!done5 && lat < 30) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    vec_t vecs[9];

    initial begin
        int lat;
        int exp_i;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [4:0] qa, qb;

        vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[7] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start5 = 0; a5 = 0; b5 = 0; bin5 = 0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_d", 32'(d8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_d", i), 32'(d8), 32'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(bout8), 32'(vecs[i].bout));
            chk($sformatf("vec%0d_busy_clr", i), 32'(busy8), 32'd0);
        end

        // D holds and DONE is a single pulse
        op8(8'h5A, 8'h23, 1'b0, lat);
        repeat (3) @(posedge CLK);
        #1;
        chk("hold_d", 32'(d8), 32'h37);
        chk("hold_done_low", 32'(done8), 32'd0);

        // asynchronous reset between edges with a nonzero result held
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("rst2_d", 32'(d8), 32'd0);
        chk("rst2_bout_done_busy", {29'd0, bout8, done8, busy8}, 32'd0);
        @(negedge CLK) RST_N = 1'b1;

        // START mid-operation is ignored
        @(negedge CLK);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0;
        @(posedge CLK);
        #1 start8 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("midstart_busy", 32'(busy8), 32'd1);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
        @(posedge CLK);
        #1 start8 = 1'b0;
        wait_done8(4, lat);
        chk("midstart_latency", 32'(lat), 32'd8);
        chk("midstart_d", 32'(d8), 32'h37);
        chk("midstart_bout", 32'(bout8), 32'd0);
        @(posedge CLK);
        #1;
        chk("midstart_no_restart", 32'(busy8), 32'd0);

        // back-to-back: START held during the DONE cycle
        op8(8'h80, 8'h01, 1'b0, lat);
        chk("b2b_first_d", 32'(d8), 32'h7F);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        @(posedge CLK);
        #1;
        start8 = 1'b0;
        chk("b2b_busy", 32'(busy8), 32'd1);
        chk("b2b_done_cleared", 32'(done8), 32'd0);
        wait_done8(0, lat);
        chk("b2b_latency", 32'(lat), 32'd8);
        chk("b2b_d", 32'(d8), 32'h0F);
        chk("b2b_bout", 32'(bout8), 32'd0);

        // reset in the middle of an operation
        @(negedge CLK);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        @(posedge CLK);
        #1 start8 = 1'b0;
        repeat (4) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("midrst_outs", {21'd0, d8, bout8, done8, busy8}, 32'd0);
        repeat (6) @(posedge CLK);
        #1;
        chk("midrst_no_done", {30'd0, done8, busy8}, 32'd0);
        @(negedge CLK) RST_N = 1'b1;
        op8(8'hC3, 8'h3C, 1'b1, lat);
        chk("midrst_fresh_latency", 32'(lat), 32'd8);
        chk("midrst_fresh_d", 32'(d8), 32'h86);
        chk("midrst_fresh_bout", 32'(bout8), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            op8(ra, rb, rbin, lat);
            exp_i = int'(ra) - int'(rb) - int'(rbin);
            checks++;
            if (lat != 8 || d8 !== 8'(exp_i) || bout8 !== (exp_i < 0)) begin
                errors++;
                $display("FAIL rnd8 %h-%h-%0d: got d=%h bout=%0d lat=%0d expected d=%h bout=%0d lat=8",
                         ra, rb, rbin, d8, bout8, lat, 8'(exp_i), (exp_i < 0));
            end
        end

        for (int i = 0; i < 1000; i++) begin
            qa = 5'($urandom); qb = 5'($urandom); rbin = 1'($urandom);
            op5(qa, qb, rbin, lat);
            exp_i = int'(qa) - int'(qb) - int'(rbin);
            checks++;
            if (lat != 5 || d5 !== 5'(exp_i) || bout5 !== (exp_i < 0)) begin
                errors++;
                $display("FAIL rnd5 %h-%h-%0d: got d=%h bout=%0d lat=%0d expected d=%h bout=%0d lat=5",
                         qa, qb, rbin, d5, bout5, lat, 5'(exp_i), (exp_i < 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
